// File: rtl/calc2_pkg.sv
// Shared calc2 types and defaults, reused by the responder, its ALU and the calc2_tb driver.
// CALC2_SHIFT_EN (optional macro) enables the SHL/SHR commands.
package calc2_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_TAG_W  = 2;

`ifdef CALC2_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    // True only for commands that take the 2-stage shift path in this build.
    function automatic logic cmd_is_shift(input logic [3:0] cmd);
        logic is_sh;
        is_sh = (cmd == CMD_SHL) || (cmd == CMD_SHR);
        return SHIFT_EN && is_sh;
    endfunction

endpackage

// File: rtl/calc2_alu.sv
// Combinational calc2 execute unit: result and status from cmd and two operands.
// The shifter exists only when CALC2_SHIFT_EN is defined.
module calc2_alu
    import calc2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output resp_e             status
);

    logic [DATA_W:0] sum;
    assign sum = {1'b0, op1} + {1'b0, op2};

`ifdef CALC2_SHIFT_EN
    localparam int SH_W = $clog2(DATA_W);
    logic [SH_W-1:0] sh_amt;
    // Only the low bits of op2 select the distance; the rest are ignored.
    assign sh_amt = op2[SH_W-1:0];
`endif

    always_comb begin
        result = '0;
        status = RESP_ERR;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    status = RESP_OK;
                    result = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    status = RESP_OK;
                    result = op1 - op2;
                end
            end
`ifdef CALC2_SHIFT_EN
            CMD_SHL: begin
                status = RESP_OK;
                result = op1 << sh_amt;
            end
            CMD_SHR: begin
                status = RESP_OK;
                result = op1 >> sh_amt;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/calc2_port_responder.sv
// Single-port calc2 responder: two-cycle request capture, 1- or 2-stage execute, registered response.
// CALC2_SHIFT_EN (optional macro) builds the shift path and its barrel stage.
module calc2_port_responder
    import calc2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAG_W  = DEFAULT_TAG_W
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic {
        ST_IDLE,
        ST_OP2
    } state_e;

    state_e state_reg, state_next;
    logic   capture, issue;
    logic   hold_off_reg;

    logic [3:0]        cmd_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] op1_reg;

    logic [DATA_W-1:0] alu_result;
    resp_e             alu_status;

    logic              s1_valid_reg;
    logic [3:0]        s1_cmd_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic [DATA_W-1:0] s1_data_reg;
    resp_e             s1_resp_reg;

    resp_e             resp_next;
    logic [DATA_W-1:0] data_next;
    logic [TAG_W-1:0]  tag_next;

    // Operand 2 goes straight from the port into the ALU during OP2.
    calc2_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd    (cmd_reg),
        .op1    (op1_reg),
        .op2    (req_data_in),
        .result (alu_result),
        .status (alu_status)
    );

    // The first edge after reset releases still ignores commands (hold_off_reg).
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_cmd_in != CMD_NONE && !hold_off_reg) begin
                    capture    = 1'b1;
                    state_next = ST_OP2;
                end
            end
            ST_OP2: begin
                issue      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (capture) begin
            cmd_reg <= req_cmd_in;
            tag_reg <= req_tag_in;
            op1_reg <= req_data_in;
        end
        if (issue) begin
            s1_cmd_reg  <= cmd_reg;
            s1_tag_reg  <= tag_reg;
            s1_data_reg <= alu_result;
            s1_resp_reg <= alu_status;
        end
    end

`ifdef CALC2_SHIFT_EN
    logic              s2_valid_reg;
    logic [3:0]        s2_cmd_reg;
    logic [TAG_W-1:0]  s2_tag_reg;
    logic [DATA_W-1:0] s2_data_reg;
    resp_e             s2_resp_reg;

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg && cmd_is_shift(s1_cmd_reg);
        end
        s2_cmd_reg  <= s1_cmd_reg;
        s2_tag_reg  <= s1_tag_reg;
        s2_data_reg <= s1_data_reg;
        s2_resp_reg <= s1_resp_reg;
    end
`endif

    // Request spacing guarantees at most one stage finishes per cycle.
    always_comb begin
        resp_next = RESP_NONE;
        data_next = '0;
        tag_next  = '0;
`ifdef CALC2_SHIFT_EN
        if (s2_valid_reg && cmd_is_shift(s2_cmd_reg)) begin
            resp_next = s2_resp_reg;
            data_next = s2_data_reg;
            tag_next  = s2_tag_reg;
        end
`endif
        if (s1_valid_reg && !cmd_is_shift(s1_cmd_reg)) begin
            resp_next = s1_resp_reg;
            data_next = s1_data_reg;
            tag_next  = s1_tag_reg;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            hold_off_reg <= 1'b1;
            s1_valid_reg <= 1'b0;
            out_resp     <= RESP_NONE;
            out_data     <= '0;
            out_tag      <= '0;
        end else begin
            state_reg    <= state_next;
            hold_off_reg <= 1'b0;
            s1_valid_reg <= issue;
            out_resp     <= resp_next;
            out_data     <= data_next;
            out_tag      <= tag_next;
        end
    end

endmodule

// File: doc/calc2_port_responder.md
# calc2_port_responder

Single-port responder for the calc2 request/response interface: accepts a two-cycle request (command, tag and first operand, then second operand) and returns a one-cycle tagged response with result and status. Intended as a synthesizable reference responder inside `calc2_tb`, so the driver's stimulus can be cross-checked against a known-good end of the interface. It can also serve as one lane of a future multi-port calc2 top.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width.
- `TAG_W`, 2: tag width.

Ports:
- `c_clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0), sampled on `c_clk` rising edge.
- `req_cmd_in`  in  4  command; 0 = no request.
- `req_data_in`  in  DATA_W  operand 1 in command cycle, operand 2 in following cycle.
- `req_tag_in`  in  TAG_W  request tag, valid in command cycle only.
- `out_resp`  out  2  0 = none, 1 = success, 2 = overflow/underflow/invalid.
- `out_data`  out  DATA_W  result; 0 when `out_resp` is not 1.
- `out_tag`  out  TAG_W  tag of the response.

## Operation
- Commands: 1 ADD, 2 SUB, 5 SHL, 6 SHR. Every other non-zero code is invalid.
- Request FSM states:
  - IDLE: on `req_cmd_in` != 0, latch cmd, tag and operand 1, then go to OP2.
  - OP2: latch `req_data_in` as operand 2, issue to execute, then return to IDLE.
  - `req_cmd_in` is ignored in OP2; it is a protocol violation and is not queued.
- Execute pipeline:
  - ADD, SUB and invalid commands use a 1-stage path.
  - SHL and SHR use a 2-stage path: an extra barrel register.
  - Each stage carries a valid bit, cmd, tag and result.
- ADD: 33-bit sum. Carry-out of 1 gives resp 2 with data 0; otherwise resp 1 with data = sum[31:0].
- SUB: op2 > op1 (unsigned) gives resp 2 with data 0; otherwise resp 1 with data = op1 − op2.
- SHL/SHR: logical shift of op1 by op2[4:0]. op2[31:5] are ignored. Always resp 1; a zero result is still success.
- Invalid command: resp 2, data 0, tag echoed.
- Outputs are registered and hold a response for exactly one cycle, then return to 0/0/0.

## Timing
- Edge E samples the command and operand 1; edge E+1 samples operand 2.
- ADD, SUB and invalid: response visible after edge E+2, for one cycle.
- SHL and SHR: response visible after edge E+3, for one cycle.
- Back-to-back: the next command is accepted at E+2 at the earliest.
- Response collisions are impossible given this spacing.
  - Shift at E, ADD at E+2 → outputs at E+3 and E+4.
  - ADD at E, shift at E+2 → outputs at E+2 and E+5.
  - Responses may therefore leave out of request order; the tag identifies them.
- Reset (`reset` = 0 at an edge):
  - FSM goes to IDLE; all pipeline valid bits clear.
  - `out_resp`, `out_data` and `out_tag` are all 0 from the next edge.
  - In-flight requests are dropped with no response, including resets during OP2 or during the shift stage.
- Command present on the same edge that reset releases: ignored.
- Tag reuse while a request is in flight: permitted. Both responses are issued in their own slots.

## Configuration
- Macro: `CALC2_SHIFT_EN`.
- Defined: SHL and SHR execute as above with 2-stage latency.
- Undefined:
  - Codes 5 and 6 are treated as invalid: resp 2, data 0, 1-stage latency.
  - Shifter and barrel stage are not built.

## Structure
- Shared package `calc2_pkg` holds:
  - `cmd_e` (NONE, ADD, SUB, SHL, SHR);
  - `resp_e` (NONE, OK, ERR);
  - `DATA_W` and `TAG_W` defaults.
  - `calc2_tb` and its driver reuse this package.
- Sub-module `calc2_alu`: combinational. It takes cmd, op1 and op2 and returns result and status. The shifter is placed under `CALC2_SHIFT_EN`. The responder owns the FSM and pipeline registers.

## Test plan
- SUB 0x22 − 0x3, tag 2 → after E+2: resp 1, data 0x1F, tag 2, held one cycle, then 0.
- ADD 0xFFFFFFFF + 0x1, tag 1 → resp 2, data 0, tag 1. SUB 0x3 − 0x4 → resp 2, data 0.
- SHL 0x1 by 0x21 (uses 1) → resp 1, data 0x2, at E+3. SHR 0x80000000 by 31 → resp 1, data 0x1.
- Shift tag 0 at E, then ADD 0x5 + 0x6 tag 3 at E+2 → tag 0 at E+3, then tag 3 with data 0xB at E+4.
- Invalid cmd 0x3, tag 1 → resp 2, data 0, tag 1 at E+2. With `CALC2_SHIFT_EN` undefined, cmd 5 → resp 2 at E+2.
- `reset` = 0 for one edge during OP2, and separately during the shift stage → no response ever emitted; outputs stay 0; next request is handled normally.
